// File: rtl/vga_driver_pkg.sv
// Shared 640x480@60 timing constants, RGB444 colour type and output pixel record
// for the VGA driver.
package vga_driver_pkg;

    localparam int unsigned CNT_W = 10;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;

    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;

    typedef logic [11:0] rgb444_t;

    localparam rgb444_t OOB_TINT = 12'h333;

    typedef struct packed {
        rgb444_t rgb;
        logic    hs_n;
        logic    vs_n;
        logic    de;
        logic    frame_start;
    } pixel_t;

    // Blanked, syncs idle high: what the outputs show while reset is held.
    localparam pixel_t PIXEL_IDLE = '{
        rgb:         12'h000,
        hs_n:        1'b1,
        vs_n:        1'b1,
        de:          1'b0,
        frame_start: 1'b0
    };

    function automatic logic in_window(input logic [CNT_W-1:0] value,
                                       input logic [CNT_W-1:0] first,
                                       input logic [CNT_W-1:0] last);
        return (value >= first) && (value <= last);
    endfunction

endpackage

// File: rtl/vga_driver_if.sv
// Character-buffer read port: pixel address out, lit/out-of-bounds flags back
// combinationally in the same cycle.
interface vga_driver_if;

    logic [6:0] read_hchar;
    logic [2:0] read_hoffset;
    logic [5:0] read_vchar;
    logic [2:0] read_voffset;
    logic       read_lit;
    logic       read_oob;

    modport master (
        output read_hchar,
        output read_hoffset,
        output read_vchar,
        output read_voffset,
        input  read_lit,
        input  read_oob
    );

    modport slave (
        input  read_hchar,
        input  read_hoffset,
        input  read_vchar,
        input  read_voffset,
        output read_lit,
        output read_oob
    );

endinterface

// File: rtl/vga_driver_counter.sv
// Wrapping up-counter 0..p_max with enable; wrap_o flags the enabled cycle
// in which the count returns to zero.
module vga_driver_counter #(
    parameter int unsigned p_width = 10,
    parameter int unsigned p_max   = 799
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    output logic [p_width-1:0] count_o,
    output logic               wrap_o
);

    localparam logic [p_width-1:0] MAX = p_width'(p_max);

    logic [p_width-1:0] count_q;
    logic [p_width-1:0] count_d;

    assign wrap_o  = en_i && (count_q == MAX);
    assign count_o = count_q;

    always_comb begin
        // NOTE: the hold value is assigned first so every path writes count_d and no latch is inferred.
        count_d = count_q;
        if (wrap_o) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + p_width'(1);
        end
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/vga_driver.sv
// VGA timing generator and pixel output stage; one registered cycle from counter to pins.
// Build option: define VGA_DRIVER_OOB_TINT_EN to tint out-of-bounds active pixels.
module vga_driver
    import vga_driver_pkg::*;
#(
    parameter int unsigned p_h_active = H_ACTIVE,
    parameter int unsigned p_h_fp     = H_FP,
    parameter int unsigned p_h_sync   = H_SYNC,
    parameter int unsigned p_h_bp     = H_BP,
    parameter int unsigned p_v_active = V_ACTIVE,
    parameter int unsigned p_v_fp     = V_FP,
    parameter int unsigned p_v_sync   = V_SYNC,
    parameter int unsigned p_v_bp     = V_BP,
    parameter rgb444_t     p_fg_color = 12'hFFF,
    parameter rgb444_t     p_bg_color = 12'h000
) (
    input  logic         clk,
    input  logic         rst,
    vga_driver_if.master rd_if,
    output logic [3:0]   vga_r_o,
    output logic [3:0]   vga_g_o,
    output logic [3:0]   vga_b_o,
    output logic         vga_hs_o,
    output logic         vga_vs_o,
    output logic         de_o,
    output logic         frame_start_o
);

    localparam int unsigned H_TOTAL = p_h_active + p_h_fp + p_h_sync + p_h_bp;
    localparam int unsigned V_TOTAL = p_v_active + p_v_fp + p_v_sync + p_v_bp;

    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(p_h_active);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(p_h_active + p_h_fp);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(p_h_active + p_h_fp + p_h_sync - 1);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(p_v_active);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(p_v_active + p_v_fp);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(p_v_active + p_v_fp + p_v_sync - 1);

    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             h_wrap;
    logic             v_wrap;
    logic             active;
    logic             at_origin_q;
    logic             at_origin_d;
    pixel_t           pixel_q;
    pixel_t           pixel_d;

    vga_driver_counter #(
        .p_width (CNT_W),
        .p_max   (H_TOTAL - 1)
    ) u_hcount (
        .clk     (clk),
        .rst     (rst),
        .en_i    (1'b1),
        .count_o (hcount),
        .wrap_o  (h_wrap)
    );

    vga_driver_counter #(
        .p_width (CNT_W),
        .p_max   (V_TOTAL - 1)
    ) u_vcount (
        .clk     (clk),
        .rst     (rst),
        .en_i    (h_wrap),
        .count_o (vcount),
        .wrap_o  (v_wrap)
    );

    assign rd_if.read_hchar   = hcount[9:3];
    assign rd_if.read_hoffset = hcount[2:0];
    assign rd_if.read_vchar   = vcount[8:3];
    assign rd_if.read_voffset = vcount[2:0];

    assign active = (hcount < H_ACT) && (vcount < V_ACT);

    // The counters sit at (0,0) out of reset and again right after the vertical wrap.
    assign at_origin_d = v_wrap;

`ifdef VGA_DRIVER_OOB_TINT_EN
    function automatic rgb444_t active_color(input logic lit, input logic oob);
        if (oob) begin
            return OOB_TINT;
        end
        return lit ? p_fg_color : p_bg_color;
    endfunction
`else
    function automatic rgb444_t active_color(input logic lit, input logic oob);
        logic oob_unused;
        oob_unused = oob;
        return lit ? p_fg_color : p_bg_color;
    endfunction
`endif

    always_comb begin
        pixel_d             = PIXEL_IDLE;
        pixel_d.hs_n        = !in_window(hcount, HS_FIRST, HS_LAST);
        pixel_d.vs_n        = !in_window(vcount, VS_FIRST, VS_LAST);
        pixel_d.de          = active;
        pixel_d.frame_start = at_origin_q;
        if (active) begin
            pixel_d.rgb = active_color(rd_if.read_lit, rd_if.read_oob);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_q     <= PIXEL_IDLE;
            at_origin_q <= 1'b1;
        end else begin
            pixel_q     <= pixel_d;
            at_origin_q <= at_origin_d;
        end
    end

    assign vga_r_o       = pixel_q.rgb[11:8];
    assign vga_g_o       = pixel_q.rgb[7:4];
    assign vga_b_o       = pixel_q.rgb[3:0];
    assign vga_hs_o      = pixel_q.hs_n;
    assign vga_vs_o      = pixel_q.vs_n;
    assign de_o          = pixel_q.de;
    assign frame_start_o = pixel_q.frame_start;

endmodule

// File: tb/tb_vga_driver.sv
// Directed bench for vga_driver: full 800-clock lines with a short 15-line frame
// so several frames fit in a short run.
module tb_vga_driver;
    import vga_driver_pkg::*;

    localparam int unsigned TB_V_ACTIVE = 8;
    localparam int unsigned TB_V_FP     = 2;
    localparam int unsigned TB_V_SYNC   = 2;
    localparam int unsigned TB_V_BP     = 3;
    localparam int unsigned FRAME       = 800 * 15;

`ifdef VGA_DRIVER_OOB_TINT_EN
    localparam logic [11:0] EXP_OOB = 12'h333;
`else
    localparam logic [11:0] EXP_OOB = 12'hFFF;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       lit_const     = 1'b1;
    logic       lit_by_offset = 1'b0;
    logic       oob           = 1'b0;
    logic [3:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, de, frame_start;
    logic [11:0] rgb;
    logic [9:0]  h_now;
    logic [8:0]  v_now;

    vga_driver_if rd_if();

    assign rd_if.read_lit = lit_by_offset ? (rd_if.read_hoffset == 3'd0) : lit_const;
    assign rd_if.read_oob = oob;
    assign rgb   = {vga_r, vga_g, vga_b};
    assign h_now = {rd_if.read_hchar, rd_if.read_hoffset};
    assign v_now = {rd_if.read_vchar, rd_if.read_voffset};

    vga_driver #(
        .p_v_active (TB_V_ACTIVE),
        .p_v_fp     (TB_V_FP),
        .p_v_sync   (TB_V_SYNC),
        .p_v_bp     (TB_V_BP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rd_if         (rd_if),
        .vga_r_o       (vga_r),
        .vga_g_o       (vga_g),
        .vga_b_o       (vga_b),
        .vga_hs_o      (vga_hs),
        .vga_vs_o      (vga_vs),
        .de_o          (de),
        .frame_start_o (frame_start)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int   hs_fall1, hs_fall2, hs_run, hs_run_max;
    int   vs_first, vs_run, vs_run_max;
    int   fs_cnt, fs_idx0, fs_idx1, de_cnt, bad_rgb;
    logic hs_prev, found;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_hs", vga_hs, 1'b1);
        check("rst_vs", vga_vs, 1'b1);
        check("rst_rgb", rgb, 12'h000);
        check("rst_de", de, 1'b0);
        check("rst_fs", frame_start, 1'b0);
        check("rst_h", h_now, 10'd0);
        check("rst_v", v_now, 9'd0);

        // Sample k shows the pixel for linear counter index k-1.
        rst        = 1'b0;
        hs_prev    = 1'b1;
        hs_fall1   = 0; hs_fall2 = 0; hs_run = 0; hs_run_max = 0;
        vs_first   = 0; vs_run = 0; vs_run_max = 0;
        fs_cnt     = 0; fs_idx0 = 0; fs_idx1 = 0; de_cnt = 0; bad_rgb = 0;
        for (int k = 1; k <= 2 * FRAME; k++) begin
            @(negedge clk);
            if (hs_prev && !vga_hs) begin
                if (hs_fall1 == 0) hs_fall1 = k;
                else if (hs_fall2 == 0) hs_fall2 = k;
            end
            hs_prev = vga_hs;
            hs_run  = vga_hs ? 0 : hs_run + 1;
            if (hs_run > hs_run_max) hs_run_max = hs_run;
            if (!vga_vs && vs_first == 0) vs_first = k;
            vs_run = vga_vs ? 0 : vs_run + 1;
            if (vs_run > vs_run_max) vs_run_max = vs_run;
            if (frame_start) begin
                fs_cnt++;
                if (fs_cnt == 1) fs_idx0 = k;
                if (fs_cnt == 2) fs_idx1 = k;
            end
            if (de) de_cnt++;
            if (de ? (rgb != 12'hFFF) : (rgb != 12'h000)) bad_rgb++;
        end
        check("hs_fall_first", hs_fall1, 657);
        check("hs_fall_period", hs_fall2 - hs_fall1, 800);
        check("hs_low_width", hs_run_max, 96);
        check("vs_fall_first", vs_first, 8001);
        check("vs_low_width", vs_run_max, 1600);
        check("fs_count", fs_cnt, 2);
        check("fs_first", fs_idx0, 1);
        check("fs_period", fs_idx1 - fs_idx0, FRAME);
        check("de_count", de_cnt, 2 * TB_V_ACTIVE * 640);
        check("rgb_vs_de", bad_rgb, 0);

        // Counters now at (0,0): lit only where the previous cycle had hoffset 0.
        check("lit_origin_h", h_now, 10'd0);
        lit_by_offset = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            check($sformatf("lit_h%0d", k - 1), rgb, ((k - 1) % 8 == 0) ? 12'hFFF : 12'h000);
        end

        lit_by_offset = 1'b0;
        oob           = 1'b1;
        @(negedge clk);
        check("oob_a", rgb, EXP_OOB);
        @(negedge clk);
        check("oob_b", rgb, EXP_OOB);
        oob = 1'b0;
        @(negedge clk);
        check("oob_off", rgb, 12'hFFF);

        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20000 && !found; i++) begin
            @(negedge clk);
            if (h_now == 10'd700 && v_now == 9'd11) found = 1'b1;
        end
        check("mid_reach", found, 1'b1);
        check("mid_hs_low", vga_hs, 1'b0);
        check("mid_vs_low", vga_vs, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("async_hs", vga_hs, 1'b1);
        check("async_vs", vga_vs, 1'b1);
        check("async_de", de, 1'b0);
        check("async_h", h_now, 10'd0);
        check("async_v", v_now, 9'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("restart_fs", frame_start, 1'b1);
        check("restart_h", h_now, 10'd1);
        check("restart_v", v_now, 9'd0);
        check("restart_hs", vga_hs, 1'b1);
        check("restart_vs", vga_vs, 1'b1);
        check("restart_de", de, 1'b1);
        @(negedge clk);
        check("restart_fs_clear", frame_start, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_driver.md
VGA_DRIVER -- requirements
Module: VgaDriver

Interface
REQ-001 SHALL have parameter p_h_active, default 640, visible pixels per line.
REQ-002 SHALL have parameters p_h_fp / p_h_sync / p_h_bp, defaults 16 / 96 / 48, horizontal front porch, sync and back porch widths in clocks.
REQ-003 SHALL have parameter p_v_active, default 480, visible lines per frame.
REQ-004 SHALL have parameters p_v_fp / p_v_sync / p_v_bp, defaults 10 / 2 / 33, vertical porch and sync widths in lines.
REQ-005 SHALL have parameters p_fg_color, default 12'hFFF, and p_bg_color, default 12'h000, giving lit and unlit RGB444 colours.
REQ-006 SHALL have port clk, input, 1, pixel clock (25 MHz nominal).
REQ-007 SHALL have port rst, input, 1; one clock, reset asynchronous and active-high.
REQ-008 SHALL have ports read_hchar (output, 7), read_hoffset (output, 3), read_vchar (output, 6) and read_voffset (output, 3), character-buffer pixel address.
REQ-009 SHALL have ports read_lit (input, 1) and read_oob (input, 1), combinational response from the character buffer.
REQ-010 SHALL have ports vga_r, vga_g and vga_b, each output, 4, pixel colour.
REQ-011 SHALL have ports vga_hs and vga_vs, each output, 1, active-low syncs.
REQ-012 SHALL have ports de (output, 1), registered display enable, and frame_start (output, 1), one-cycle pulse.

Function
REQ-013 SHALL keep 10-bit hcount running 0..H_TOTAL-1, where H_TOTAL = sum of the horizontal parameters (800), and wrap to 0.
REQ-014 SHALL increment 10-bit vcount only when hcount wraps, running 0..V_TOTAL-1 (525), and wrap to 0.
REQ-015 SHALL drive read_hchar/read_hoffset = hcount[9:3]/hcount[2:0] and read_vchar/read_voffset = vcount[8:3]/vcount[2:0], combinationally from the counters.
REQ-016 SHALL treat active as (hcount < p_h_active) AND (vcount < p_v_active).
REQ-017 SHALL register every output one cycle after its counter state, so the pixel for counter (h,v) appears at cycle t+1 with its own hs, vs and de.
REQ-018 SHALL assert vga_hs low exactly for hcount in [p_h_active+p_h_fp, p_h_active+p_h_fp+p_h_sync-1], i.e. 656..751.
REQ-019 SHALL assert vga_vs low exactly for vcount in [p_v_active+p_v_fp, p_v_active+p_v_fp+p_v_sync-1], i.e. 490..491, for whole lines.
REQ-020 SHALL output colour when active: p_fg_color if read_lit, else p_bg_color; when not active, rgb SHALL be 12'h000.
REQ-021 SHALL pulse frame_start for exactly one cycle, the output cycle for counter (0,0).
REQ-022 SHALL treat read_lit and read_oob as don't-care outside active.

Reset
REQ-023 SHALL, while rst is high, hold hcount = vcount = 0, vga_hs = vga_vs = 1, rgb = 0, de = 0 and frame_start = 0.
REQ-024 SHALL, after rst deasserts, present counter (0,0) in the first cycle and its output pixel in the second, including the frame_start pulse.
REQ-025 SHALL, on reset mid-frame, abort the frame immediately with no partial sync pulse extension.

Configuration
REQ-026 SHALL, with VGA_DRIVER_OOB_TINT_EN defined, colour active pixels with read_oob = 1 as 12'h333 regardless of read_lit.
REQ-027 SHALL, without VGA_DRIVER_OOB_TINT_EN, ignore read_oob and colour active pixels per REQ-020.

Structure
REQ-028 SHALL place the 640x480 timing constants, the RGB444 colour typedef and the OOB tint constant in shared package VgaPkg.
REQ-029 SHALL contain one sub-module, VgaCounter: a parameterised wrapping counter with a wrap output, instanced once for horizontal and once for vertical with enable = horizontal wrap.

Verification
REQ-030 SHALL verify: release reset, count 800 clocks -> second vga_hs falling edge exactly 800 cycles after the first; hs low 96 cycles.
REQ-031 SHALL verify: run 420000 cycles -> frame_start pulses exactly once per 420000 cycles; vs low 1600 consecutive cycles.
REQ-032 SHALL verify: read_lit tied 1 -> rgb 12'hFFF with de=1 for 307200 cycles per frame, 12'h000 elsewhere.
REQ-033 SHALL verify: read_lit = (read_hoffset==0) -> output lit on cycle following hcount 0, 8, 16 only; confirms one-cycle latency.
REQ-034 SHALL verify: read_oob=1, read_lit=1 -> rgb 12'h333 with macro defined, 12'hFFF without.
REQ-035 SHALL verify: assert rst at hcount 700, vcount 491 -> vga_hs and vga_vs high asynchronously; restart at (0,0) after release.
